// File: rtl/motor_pwm_pkg.sv
// Shared types and default parameters for the multi-channel motor PWM controller.
package motor_pwm_pkg;
  typedef enum logic [1:0] {IDLE, RAMP, RUN, DEAD} ch_state_t;

  localparam int DEF_NUM_CH   = 2;
  localparam int DEF_CNT_W    = 16;
  localparam int DEF_SPD_W    = 8;
  localparam int DEF_PERIOD   = 10000;
  localparam int DEF_RAMP_DIV = 100;
  localparam int DEF_DEAD_CYC = 50;
endpackage

// File: rtl/motor_pwm_ch.sv
// One motor channel: state machine, speed ramp, per-period duty latch and PWM compare.
// ma is registered and lags the shared counter by one cycle.
module motor_pwm_ch
  import motor_pwm_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SPD_W    = DEF_SPD_W,
  parameter int PERIOD   = DEF_PERIOD,
  parameter int DEAD_CYC = DEF_DEAD_CYC
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             tick,
  input  logic             cnt_last,
  input  logic [CNT_W-1:0] cnt,
  input  logic             dir,
  input  logic [SPD_W-1:0] spd_sel,
  input  logic [CNT_W-1:0] period_stopped,
  input  logic [7:0]       spd_scaling,
  output logic [1:0]       ma,
  output logic             motor_en,
  output logic             busy,
  output logic [CNT_W:0]   duty_cur
);
  localparam int DW  = CNT_W + SPD_W + 10;
  localparam int DCW = $clog2(DEAD_CYC + 1);
  localparam logic [CNT_W:0] PER = (CNT_W+1)'(PERIOD);

  ch_state_t        state;
  logic [SPD_W-1:0] spd_cur;
  logic             dir_cur;
  logic [DCW-1:0]   dead_cnt;

  logic [DW-1:0]    sum;
  logic [CNT_W:0]   duty_nxt;
  logic [CNT_W:0]   cmp;
  logic [SPD_W-1:0] tgt;
  logic             pwm;

  // Wide intermediate keeps the full product so saturation never sees a wrapped value.
  assign sum      = DW'(period_stopped) + DW'(spd_scaling) * DW'(spd_cur);
  assign duty_nxt = (sum > DW'(PERIOD)) ? PER : sum[CNT_W:0];
  assign cmp      = dir_cur ? duty_cur : PER - duty_cur;
  assign pwm      = {1'b0, cnt} < cmp;
  assign tgt      = (dir == dir_cur) ? spd_sel : '0;

  assign motor_en = (state != IDLE);
  assign busy     = (state == RAMP) || (state == DEAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      spd_cur  <= '0;
      dir_cur  <= 1'b1;
      duty_cur <= '0;
      ma       <= 2'b00;
      dead_cnt <= '0;
    end else if (!en) begin
      state    <= IDLE;
      spd_cur  <= '0;
      duty_cur <= '0;
      ma       <= 2'b00;
      dead_cnt <= '0;
    end else begin
      if (cnt_last) duty_cur <= duty_nxt;
      ma <= (state == RAMP || state == RUN) ? {~pwm, pwm} : 2'b00;
      case (state)
        IDLE: begin
          spd_cur <= '0;
          if (spd_sel != '0) begin
            dir_cur <= dir;
            state   <= RAMP;
          end
        end
        RAMP: begin
          if (spd_cur == tgt && tgt != '0) begin
            state <= RUN;
          end else if (spd_cur == '0 && tgt == '0) begin
            state <= (spd_sel == '0) ? IDLE : DEAD;
          end else if (tick) begin
            if (spd_cur < tgt) spd_cur <= spd_cur + 1'b1;
            else               spd_cur <= spd_cur - 1'b1;
          end
        end
        RUN: begin
          if (spd_sel != spd_cur || dir != dir_cur) state <= RAMP;
        end
        DEAD: begin
          // Target is only looked at on the way out of the coast window.
          if (dead_cnt == DCW'(DEAD_CYC - 1)) begin
            dead_cnt <= '0;
            dir_cur  <= dir;
            state    <= (spd_sel == '0) ? IDLE : RAMP;
          end else begin
            dead_cnt <= dead_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/motor_pwm_mc.sv
// Multi-channel motor PWM top: shared period counter, ramp prescaler and busy reduction.
module motor_pwm_mc
  import motor_pwm_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SPD_W    = DEF_SPD_W,
  parameter int PERIOD   = DEF_PERIOD,
  parameter int RAMP_DIV = DEF_RAMP_DIV,
  parameter int DEAD_CYC = DEF_DEAD_CYC
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [NUM_CH-1:0]             dir,
  input  logic [NUM_CH-1:0][SPD_W-1:0]  spd_sel,
  input  logic [CNT_W-1:0]              period_stopped,
  input  logic [7:0]                    spd_scaling,
  output logic [NUM_CH-1:0][1:0]        ma,
  output logic [NUM_CH-1:0]             motor_en,
  output logic [NUM_CH-1:0][CNT_W:0]    duty_cur,
  output logic                          busy
);
  localparam int PW = $clog2(RAMP_DIV + 1);

  logic [CNT_W-1:0]  cnt;
  logic [PW-1:0]     pre;
  logic              cnt_last;
  logic              tick;
  logic [NUM_CH-1:0] ch_busy;

  assign cnt_last = (cnt == CNT_W'(PERIOD - 1));
  assign tick     = en && (pre == PW'(RAMP_DIV - 1));
  assign busy     = |ch_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      pre <= '0;
    end else if (!en) begin
      cnt <= '0;
      pre <= '0;
    end else begin
      cnt <= cnt_last ? '0 : cnt + 1'b1;
      pre <= tick ? '0 : pre + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    motor_pwm_ch #(
      .CNT_W   (CNT_W),
      .SPD_W   (SPD_W),
      .PERIOD  (PERIOD),
      .DEAD_CYC(DEAD_CYC)
    ) u_ch (
      .clk           (clk),
      .rst           (rst),
      .en            (en),
      .tick          (tick),
      .cnt_last      (cnt_last),
      .cnt           (cnt),
      .dir           (dir[gi]),
      .spd_sel       (spd_sel[gi]),
      .period_stopped(period_stopped),
      .spd_scaling   (spd_scaling),
      .ma            (ma[gi]),
      .motor_en      (motor_en[gi]),
      .busy          (ch_busy[gi]),
      .duty_cur      (duty_cur[gi])
    );
  end
endmodule

// File: tb/tb_motor_pwm_mc.sv
// Directed bench for motor_pwm_mc with PERIOD=100, RAMP_DIV=4, DEAD_CYC=8.
module tb_motor_pwm_mc;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 16;
  localparam int SPD_W  = 8;

  logic                         clk;
  logic                         rst;
  logic                         en;
  logic [NUM_CH-1:0]            dir;
  logic [NUM_CH-1:0][SPD_W-1:0] spd_sel;
  logic [CNT_W-1:0]             period_stopped;
  logic [7:0]                   spd_scaling;
  logic [NUM_CH-1:0][1:0]       ma;
  logic [NUM_CH-1:0]            motor_en;
  logic [NUM_CH-1:0][CNT_W:0]   duty_cur;
  logic                         busy;

  int checks = 0;
  int errors = 0;
  int cyc;
  int dead_seen;
  int h0, h1, nc0;

  motor_pwm_mc #(
    .NUM_CH  (NUM_CH),
    .CNT_W   (CNT_W),
    .SPD_W   (SPD_W),
    .PERIOD  (100),
    .RAMP_DIV(4),
    .DEAD_CYC(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .dir           (dir),
    .spd_sel       (spd_sel),
    .period_stopped(period_stopped),
    .spd_scaling   (spd_scaling),
    .ma            (ma),
    .motor_en      (motor_en),
    .duty_cur      (duty_cur),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Over one full period: high cycles of ma[0][0] and ma[1][0], and ch0 non-complementary cycles.
  task automatic meas(output int hi0, output int hi1, output int bad0);
    hi0 = 0; hi1 = 0; bad0 = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); @(negedge clk);
      if (ma[0][0]) hi0++;
      if (ma[1][0]) hi1++;
      if (ma[0][0] == ma[0][1]) bad0++;
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; dir = 2'b11; spd_sel = '0;
    period_stopped = 16'd10; spd_scaling = 8'd1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ma",    32'(ma), 0);
    chk("rst_men",   32'(motor_en), 0);
    chk("rst_duty0", 32'(duty_cur[0]), 0);
    chk("rst_duty1", 32'(duty_cur[1]), 0);
    chk("rst_busy",  32'(busy), 0);

    // Ramp ch0 up to 30 forward
    rst = 1'b0; en = 1'b1; spd_sel[0] = 8'd30;
    cyc = 0;
    do begin
      @(posedge clk); @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        chk("ramp_busy", 32'(busy), 1);
        chk("ramp_men",  32'(motor_en), 32'd1);
      end
    end while (busy && cyc < 500);
    chk("ramp_cycles", cyc, 121);
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk("fwd_duty0", 32'(duty_cur[0]), 40);
    chk("idle_duty1", 32'(duty_cur[1]), 10);
    meas(h0, h1, nc0);
    chk("fwd_high0", h0, 40);
    chk("fwd_compl0", nc0, 0);
    chk("idle_high1", h1, 0);

    // Reversal: coast window must be exactly 8 cycles of ma=00 with busy
    dir[0] = 1'b0;
    dead_seen = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); @(negedge clk);
      if (ma[0] == 2'b00 && busy) dead_seen++;
    end
    chk("rev_dead", dead_seen, 8);
    chk("rev_busy", 32'(busy), 0);
    chk("rev_duty0", 32'(duty_cur[0]), 40);
    meas(h0, h1, nc0);
    chk("rev_high0", h0, 60);

    // Independence: ch1 forward at 20 while ch0 reverse at 30
    dir[1] = 1'b1; spd_sel[1] = 8'd20;
    repeat (400) @(posedge clk);
    @(negedge clk);
    chk("ind_duty1", 32'(duty_cur[1]), 30);
    chk("ind_duty0", 32'(duty_cur[0]), 40);
    meas(h0, h1, nc0);
    chk("ind_high0", h0, 60);
    chk("ind_high1", h1, 30);

    // Enable drop mid-ramp on both channels
    spd_sel[0] = 8'd50; spd_sel[1] = 8'd60;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    en = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("dis_ma",    32'(ma), 0);
    chk("dis_duty0", 32'(duty_cur[0]), 0);
    chk("dis_duty1", 32'(duty_cur[1]), 0);
    chk("dis_men",   32'(motor_en), 0);
    chk("dis_busy",  32'(busy), 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    en = 1'b1;
    repeat (99) @(posedge clk);
    @(negedge clk);
    chk("reen_duty0_pre", 32'(duty_cur[0]), 0);
    @(posedge clk); @(negedge clk);
    chk("reen_duty0", 32'(duty_cur[0]), 34);
    chk("reen_duty1", 32'(duty_cur[1]), 34);

    // Asynchronous reset between clock edges
    repeat (30) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_ma",    32'(ma), 0);
    chk("arst_men",   32'(motor_en), 0);
    chk("arst_duty0", 32'(duty_cur[0]), 0);
    chk("arst_duty1", 32'(duty_cur[1]), 0);
    chk("arst_busy",  32'(busy), 0);

    // Saturation after release; first latch 100 edges later shows the counter restarted at 0
    @(negedge clk);
    period_stopped = 16'd50; spd_scaling = 8'd255;
    spd_sel[0] = 8'd255; spd_sel[1] = 8'd0; dir = 2'b11;
    rst = 1'b0;
    repeat (99) @(posedge clk);
    @(negedge clk);
    chk("sat_duty_pre", 32'(duty_cur[0]), 0);
    @(posedge clk); @(negedge clk);
    chk("sat_duty0", 32'(duty_cur[0]), 100);
    chk("sat_duty1", 32'(duty_cur[1]), 50);
    repeat (10) @(posedge clk);
    @(negedge clk);
    meas(h0, h1, nc0);
    chk("sat_high0", h0, 100);
    chk("sat_high1", h1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule
